iter_alu: RTL and testbench

- Parametrised, multi-cycle successor to the single-cycle EX-stage ALU.
- Executes logic, shift, add/sub and compare ops in one cycle, and mul/div/rem iteratively.
- Uses a valid/ready handshake on both input and output so the pipeline can stall on long ops.
- Sits in the EX stage between the ID/EX register and the EX/MEM register; the hazard unit stalls the front end while ready_o is low.

---
 rtl/iter_alu.sv | 228 ++++++++++++++++++++++
 tb/tb_iter_alu.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/iter_alu.sv
// iter_alu: multi-cycle EX-stage ALU with valid/ready handshakes on both sides.
// Logic, shift, add/sub and compare ops finish in one cycle. mul runs as a
// shift-add loop and div/rem as a restoring divider, one bit per cycle.
//
// Ports:
//   clk_i      rising-edge clock
//   rst_i      asynchronous active-low reset
//   valid_i    opcode/operands valid; accepted when ready_o is high
//   ready_o    high only in IDLE
//   ALUCtrl_i  4-bit opcode
//   data1_i    operand A (rs1)
//   data2_i    operand B (rs2 or immediate); shifts use data2_i[SHW-1:0]
//   valid_o    result valid, held until ready_i
//   ready_i    consumer accepts the result
//   data_o     result
//   Zero_o     data_o == 0, qualified by valid_o
//   busy_o     high while an iterative op is running
//
// Build option: define ITER_ALU_DIV_EN to include the divider. Without it,
// div/rem complete in one cycle with a zero result.

module iter_alu #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             busy_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_XOR  = 4'b0001;
  localparam logic [3:0] OP_SLL  = 4'b0010;
  localparam logic [3:0] OP_ADD  = 4'b0011;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_MUL  = 4'b0101;
  localparam logic [3:0] OP_OR   = 4'b0110;
  localparam logic [3:0] OP_SRA  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SLT  = 4'b1001;
  localparam logic [3:0] OP_SLTU = 4'b1010;
`ifdef ITER_ALU_DIV_EN
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_REM  = 4'b1100;
`endif

`ifdef ITER_ALU_DIV_EN
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DIV = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, MUL = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;
  logic [WIDTH-1:0] single_res;

  // Single-cycle result. div/rem land in the default arm, which is what the
  // divider-less build returns for them.
  function automatic logic [WIDTH-1:0] single_op(input logic [3:0]       op,
                                                 input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
    logic [SHW-1:0] sh;
    sh = b[SHW-1:0];
    case (op)
      OP_AND:  single_op = a & b;
      OP_XOR:  single_op = a ^ b;
      OP_SLL:  single_op = a << sh;
      OP_ADD:  single_op = a + b;
      OP_SUB:  single_op = a - b;
      OP_OR:   single_op = a | b;
      OP_SRA:  single_op = $signed(a) >>> sh;
      OP_SRL:  single_op = a >> sh;
      OP_SLT:  single_op = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SLTU: single_op = {{(WIDTH-1){1'b0}}, (a < b)};
      default: single_op = '0;
    endcase
  endfunction

  always_comb begin
    single_res = single_op(ALUCtrl_i, data1_i, data2_i);
    acc_next   = acc + (mplier[0] ? mcand : '0);
  end

`ifdef ITER_ALU_DIV_EN
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] rem_r;
  logic [WIDTH-1:0] dmag;
  logic [WIDTH-1:0] rem_next;
  logic [WIDTH-1:0] quo_next;
  logic [WIDTH-1:0] div_result;
  logic [WIDTH:0]   shifted;
  logic             ge;
  logic             q_neg;
  logic             r_neg;
  logic             is_rem;
  logic             div_zero;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    magnitude = v[WIDTH-1] ? -v : v;
  endfunction

  // One restoring step: dvd shifts dividend bits out of the top while
  // quotient bits enter at the bottom. A zero divisor naturally yields
  // all-ones magnitude and a remainder equal to the dividend, but the
  // quotient must stay all ones regardless of sign, hence div_zero.
  always_comb begin
    shifted    = {rem_r, dvd[WIDTH-1]};
    ge         = (shifted >= {1'b0, dmag});
    rem_next   = ge ? (shifted[WIDTH-1:0] - dmag) : shifted[WIDTH-1:0];
    quo_next   = {dvd[WIDTH-2:0], ge};
    div_result = '0;
    if (is_rem)
      div_result = r_neg ? -rem_next : rem_next;
    else if (div_zero)
      div_result = '1;
    else
      div_result = q_neg ? -quo_next : quo_next;
  end

  assign busy_o = (state == MUL) || (state == DIV);
`else
  assign busy_o = (state == MUL);
`endif

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

  // Main FSM: operands are captured on accept, iterative ops count WIDTH
  // steps, and the result is registered on the transition into DONE.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= IDLE;
      count  <= '0;
      data_o <= '0;
      Zero_o <= 1'b0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
`ifdef ITER_ALU_DIV_EN
      dvd      <= '0;
      rem_r    <= '0;
      dmag     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      is_rem   <= 1'b0;
      div_zero <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (valid_i) begin
            count <= '0;
            case (ALUCtrl_i)
              OP_MUL: begin
                mcand  <= data1_i;
                mplier <= data2_i;
                acc    <= '0;
                state  <= MUL;
              end
`ifdef ITER_ALU_DIV_EN
              OP_DIV, OP_REM: begin
                dvd      <= magnitude(data1_i);
                rem_r    <= '0;
                dmag     <= magnitude(data2_i);
                q_neg    <= data1_i[WIDTH-1] ^ data2_i[WIDTH-1];
                r_neg    <= data1_i[WIDTH-1];
                is_rem   <= (ALUCtrl_i == OP_REM);
                div_zero <= (data2_i == '0);
                state    <= DIV;
              end
`endif
              default: begin
                data_o <= single_res;
                Zero_o <= (single_res == '0);
                state  <= DONE;
              end
            endcase
          end
        end
        MUL: begin
          acc    <= acc_next;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          count  <= count + CW'(1);
          if (count == LAST) begin
            data_o <= acc_next;
            Zero_o <= (acc_next == '0);
            state  <= DONE;
          end
        end
`ifdef ITER_ALU_DIV_EN
        DIV: begin
          rem_r <= rem_next;
          dvd   <= quo_next;
          count <= count + CW'(1);
          if (count == LAST) begin
            data_o <= div_result;
            Zero_o <= (div_result == '0);
            state  <= DONE;
          end
        end
`endif
        DONE: begin
          if (ready_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iter_alu.sv
// tb_iter_alu: directed self-checking bench for iter_alu (WIDTH=32).
// A protocol/result model predicts valid_o, ready_o, busy_o, data_o and
// Zero_o every cycle; directed vectors also pin literal results, latency and
// busy duration. Div expectations follow the ITER_ALU_DIV_EN build option.

module tb_iter_alu;

  localparam int WIDTH = 32;

  logic             clk_i = 1'b0;
  logic             rst_i = 1'b1;
  logic             valid_i = 1'b0;
  logic             ready_i = 1'b0;
  logic [3:0]       ALUCtrl_i = 4'd0;
  logic [WIDTH-1:0] data1_i = '0;
  logic [WIDTH-1:0] data2_i = '0;
  logic             ready_o;
  logic             valid_o;
  logic [WIDTH-1:0] data_o;
  logic             Zero_o;
  logic             busy_o;

  iter_alu #(.WIDTH(WIDTH)) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o),
    .busy_o    (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  bit cmp_en   = 1'b0;

  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Architectural result of an opcode, from plain 64-bit arithmetic.
  function automatic logic [31:0] model_result(input logic [3:0] op, input logic [31:0] a,
                                               input logic [31:0] b);
    longint   sa;
    longint   sb;
    logic [4:0] sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = b[4:0];
    case (op)
      4'd0:  return a & b;
      4'd1:  return a ^ b;
      4'd2:  return a << sh;
      4'd3:  return a + b;
      4'd4:  return a - b;
      4'd5:  return 32'(sa * sb);
      4'd6:  return a | b;
      4'd7:  return 32'(sa >>> sh);
      4'd8:  return a >> sh;
      4'd9:  return (sa < sb) ? 32'd1 : 32'd0;
      4'd10: return (a < b) ? 32'd1 : 32'd0;
`ifdef ITER_ALU_DIV_EN
      4'd11: return (b == 32'd0) ? 32'hFFFF_FFFF : 32'(sa / sb);
      4'd12: return (b == 32'd0) ? a : 32'(sa % sb);
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic int model_latency(input logic [3:0] op);
    if (op == 4'd5) return WIDTH + 1;
`ifdef ITER_ALU_DIV_EN
    if (op == 4'd11 || op == 4'd12) return WIDTH + 1;
`endif
    return 1;
  endfunction

  // Handshake-level model: idle -> (busy for latency-1 edges) -> done -> idle.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mphase_t;
  mphase_t     m_phase = M_IDLE;
  int          m_left  = 0;
  logic [31:0] m_exp   = '0;

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_phase <= M_IDLE;
      m_left  <= 0;
      m_exp   <= '0;
    end else begin
      case (m_phase)
        M_IDLE: if (valid_i) begin
          m_exp   <= model_result(ALUCtrl_i, data1_i, data2_i);
          m_left  <= model_latency(ALUCtrl_i) - 1;
          m_phase <= (model_latency(ALUCtrl_i) == 1) ? M_DONE : M_BUSY;
        end
        M_BUSY: begin
          if (m_left == 1) m_phase <= M_DONE;
          else m_left <= m_left - 1;
        end
        M_DONE: if (ready_i) m_phase <= M_IDLE;
        default: m_phase <= M_IDLE;
      endcase
    end
  end

  // Per-cycle compare against the model.
  always @(negedge clk_i) begin
    if (rst_i && cmp_en) begin
      checkOutput("cyc_valid", 32'(valid_o), 32'(m_phase == M_DONE));
      checkOutput("cyc_ready", 32'(ready_o), 32'(m_phase == M_IDLE));
      checkOutput("cyc_busy",  32'(busy_o),  32'(m_phase == M_BUSY));
      if (m_phase == M_DONE) begin
        checkOutput("cyc_data", data_o, m_exp);
        checkOutput("cyc_zero", 32'(Zero_o), 32'(m_exp == 32'd0));
      end
    end
  end

  // Issue one op, wait for its result, check literals, optionally hold off
  // the consumer for `hold` cycles, then complete the output handshake.
  task automatic applyStimulus(input string name, input logic [3:0] op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] exp_data,
                               input int exp_lat, input int exp_busy, input int hold);
    int waited;
    int start;
    int lat;
    int busy_cnt;
    waited = 0;
    while (!ready_o && waited < 50) begin
      @(negedge clk_i);
      waited++;
    end
    checkOutput({name, "_ready_before"}, 32'(ready_o), 32'd1);
    valid_i   = 1'b1;
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i   = 1'b0;
    ALUCtrl_i = 4'($urandom);
    data1_i   = $urandom;
    data2_i   = $urandom;
    start     = cyc;
    busy_cnt  = 0;
    while (!valid_o && (cyc - start) < 200) begin
      if (busy_o) busy_cnt++;
      @(negedge clk_i);
    end
    lat = cyc - start + 1;
    checkOutput({name, "_valid"}, 32'(valid_o), 32'd1);
    checkOutput({name, "_latency"}, 32'(lat), 32'(exp_lat));
    checkOutput({name, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_busy));
    checkOutput({name, "_data"}, data_o, exp_data);
    checkOutput({name, "_zero"}, 32'(Zero_o), 32'(exp_data == 32'd0));
    for (int i = 0; i < hold; i++) begin
      valid_i   = 1'b1;
      ALUCtrl_i = 4'd3;
      data1_i   = 32'd1;
      data2_i   = 32'd1;
      @(negedge clk_i);
      checkOutput({name, "_hold_data"}, data_o, exp_data);
      checkOutput({name, "_hold_ready"}, 32'(ready_o), 32'd0);
      checkOutput({name, "_hold_valid"}, 32'(valid_o), 32'd1);
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(negedge clk_i);
    ready_i = 1'b0;
    checkOutput({name, "_idle_after"}, 32'(ready_o), 32'd1);
  endtask

  initial begin
    $display("[TB] start");
    #1 rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_data",  data_o, 32'd0);
    checkOutput("rst_zero",  32'(Zero_o), 32'd0);
    checkOutput("rst_valid", 32'(valid_o), 32'd0);
    checkOutput("rst_busy",  32'(busy_o), 32'd0);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("rst_ready", 32'(ready_o), 32'd1);
    cmp_en = 1'b1;

    // Reset in the middle of a multiply.
    valid_i = 1'b1; ALUCtrl_i = 4'd5; data1_i = 32'd7; data2_i = 32'd6;
    @(posedge clk_i);
    @(negedge clk_i);
    valid_i = 1'b0;
    repeat (4) @(negedge clk_i);
    checkOutput("midmul_busy_before", 32'(busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    checkOutput("midmul_rst_valid", 32'(valid_o), 32'd0);
    checkOutput("midmul_rst_data",  data_o, 32'd0);
    checkOutput("midmul_rst_busy",  32'(busy_o), 32'd0);
    checkOutput("midmul_rst_zero",  32'(Zero_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    checkOutput("midmul_ready_after", 32'(ready_o), 32'd1);
    applyStimulus("add_2_3", 4'd3, 32'd2, 32'd3, 32'd5, 1, 0, 0);

    // Single-cycle ops.
    applyStimulus("sub_5_5",   4'd4,  32'd5, 32'd5, 32'd0, 1, 0, 0);
    applyStimulus("sra_4",     4'd7,  32'h8000_0000, 32'd4, 32'hF800_0000, 1, 0, 0);
    applyStimulus("srl_36",    4'd8,  32'h8000_0000, 32'd36, 32'h0800_0000, 1, 0, 0);
    applyStimulus("sll_31",    4'd2,  32'd1, 32'd31, 32'h8000_0000, 1, 0, 0);
    applyStimulus("sltu",      4'd10, 32'd1, 32'hFFFF_FFFF, 32'd1, 1, 0, 0);
    applyStimulus("slt",       4'd9,  32'd1, 32'hFFFF_FFFF, 32'd0, 1, 0, 0);
    applyStimulus("and",       4'd0,  32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1, 0, 0);
    applyStimulus("xor",       4'd1,  32'hFF00_FF00, 32'h0F0F_0F0F, 32'hF00F_F00F, 1, 0, 0);
    applyStimulus("or",        4'd6,  32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1, 0, 0);
    applyStimulus("add_wrap",  4'd3,  32'hFFFF_FFFF, 32'd2, 32'd1, 1, 0, 0);
    applyStimulus("op_1101",   4'd13, 32'd5, 32'd5, 32'd0, 1, 0, 0);

    // Iterative multiply.
    applyStimulus("mul_m3_7",  4'd5, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFEB, 33, 32, 0);
    applyStimulus("mul_7_6",   4'd5, 32'd7, 32'd6, 32'd42, 33, 32, 0);
    applyStimulus("mul_wrap",  4'd5, 32'h0001_0000, 32'h0001_0000, 32'd0, 33, 32, 0);

`ifdef ITER_ALU_DIV_EN
    applyStimulus("div_m20_6", 4'd11, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFD, 33, 32, 0);
    applyStimulus("rem_m20_6", 4'd12, 32'hFFFF_FFEC, 32'd6, 32'hFFFF_FFFE, 33, 32, 0);
    applyStimulus("div_9_0",   4'd11, 32'd9, 32'd0, 32'hFFFF_FFFF, 33, 32, 0);
    applyStimulus("rem_9_0",   4'd12, 32'd9, 32'd0, 32'd9, 33, 32, 0);
    applyStimulus("div_ovf",   4'd11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 33, 32, 0);
    applyStimulus("rem_ovf",   4'd12, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 33, 32, 0);
    applyStimulus("div_100_7", 4'd11, 32'd100, 32'd7, 32'd14, 33, 32, 0);
`else
    applyStimulus("div_9_3_nodiv", 4'd11, 32'd9, 32'd3, 32'd0, 1, 0, 0);
    applyStimulus("rem_9_3_nodiv", 4'd12, 32'd9, 32'd3, 32'd0, 1, 0, 0);
`endif

    // Output backpressure, then a fresh accept.
    applyStimulus("bp_sub",    4'd4, 32'd10, 32'd3, 32'd7, 1, 0, 10);
    applyStimulus("bp_after",  4'd3, 32'd100, 32'd23, 32'd123, 1, 0, 0);

    repeat (2) @(negedge clk_i);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
